cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Shares the single SRAM-like memory port behind the caches between the instruction-cache miss path (inst) and the write-back data-cache miss/write-back path (data).
- Allows exactly one outstanding transaction at a time.
- Priority is data-first, with a bounded-streak fairness counter so instruction fetch cannot starve.
- Sits between the two cache blocks and the SRAM-to-AXI bridge.

Parameters:
- STREAK_MAX, 4: maximum consecutive data grants while inst is waiting; must be ≥1.
- CNT_W, $clog2(STREAK_MAX+1): width of the streak counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  inst master request
- inst_wr  in  1  write enable (normally 0)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_addr  in  32  byte address
- inst_wdata  in  32  write data
- inst_rdata  out  32  read data
- inst_addr_ok  out  1  address accepted
- inst_data_ok  out  1  transaction complete
- data_req, data_wr, data_size, data_addr, data_wdata, data_rdata, data_addr_ok, data_data_ok: identical set for the data master
- mem_req  out  1  request to memory port
- mem_wr  out  1  forwarded write enable
- mem_size  out  2  forwarded size
- mem_addr  out  32  forwarded address
- mem_wdata  out  32  forwarded write data
- mem_rdata  in  32  memory read data
- mem_addr_ok  in  1  memory accepted address
- mem_data_ok  in  1  memory completed transaction

Behaviour:
- Reset:
  - Clocked on clk, synchronous, active-high; overrides everything in the same edge.
  - state=IDLE, owner=DATA, streak=0.
  - While rst=1: mem_req, *_addr_ok, *_data_ok are all 0.
- States:
  - IDLE: no transaction.
  - ADDR: grant latched, waiting for mem_addr_ok.
  - DATA: address accepted, waiting for mem_data_ok.
- Arbitration (combinational, IDLE only):
  - Only data_req: grant DATA.
  - Only inst_req: grant INST.
  - Both: grant INST if streak==STREAK_MAX, else DATA.
  - Neither: mem_req=0.
- Forwarding:
  - mem_req/wr/size/addr/wdata come from the current grant in IDLE, and from the latched owner in ADDR.
  - In ADDR: mem_req=1 regardless of the owner's req. Masters must hold req and payload until addr_ok; dropping req is a protocol violation and is not checked.
  - In DATA: mem_req=0.
  - In IDLE with no request: payload is don't-care, mem_req=0.
- Handshake routing:
  - owner_addr_ok = mem_addr_ok && mem_req && (master is grant/owner); the other master's addr_ok=0.
  - owner_data_ok = mem_data_ok && state!=IDLE-without-grant && (master is owner).
  - mem_rdata drives both inst_rdata and data_rdata; it is valid only with that master's data_ok.
- Transitions:
  - IDLE, grant, no addr_ok → ADDR; latch owner.
  - IDLE/ADDR, addr_ok, no data_ok → DATA; latch owner.
  - IDLE/ADDR, addr_ok and data_ok in the same cycle (zero-latency memory) → IDLE; that master gets both oks in that cycle.
  - DATA, data_ok → IDLE.
  - A new grant is possible the cycle after data_ok (IDLE arbitrates combinationally). Minimum back-to-back spacing: 1 cycle between one data_ok and the next addr_ok.
  - mem_data_ok while IDLE with no grant: ignored; no data_ok is asserted.
- Streak counter, updated at each addr handshake:
  - DATA granted and inst_req=1: streak = min(streak+1, STREAK_MAX).
  - DATA granted and inst_req=0: streak=0.
  - INST granted: streak=0.
- Reset mid-transaction: the arbiter returns to IDLE and does not track the in-flight transaction. The memory port is reset by the same rst.

Decomposition:
- Shared package (cache bus package): state encoding IDLE=2'b00, ADDR=2'b01, DATA=2'b10; master IDs INST=1'b0, DATA=1'b1; size codes SZ_BYTE/SZ_HALF/SZ_WORD.
- Optional sub-module bus_prio_pick: combinational two-input priority picker with streak override, taking inst_req, data_req and streak_full, and producing grant_valid and grant_id.
- Everything else stays in one module.

Test Plan:
- Single inst read, memory addr_ok after 2 cycles, data_ok 3 cycles later, rdata=32'hDEADBEEF → inst_addr_ok exactly once, inst_data_ok with inst_rdata=32'hDEADBEEF, data_* oks stay 0, state returns to IDLE.
- inst_req and data_req held together, data write to 32'h1000_0040 with wdata 32'h1234_5678 → mem_addr=32'h1000_0040, mem_wr=1, mem_wdata=32'h1234_5678; data granted first, inst granted immediately after data_data_ok.
- data_req continuously asserted for 10 transactions, inst_req held, STREAK_MAX=4 → grant order D,D,D,D,I,D,D,D,D,I; streak resets to 0 after each inst grant.
- Zero-latency memory (addr_ok and data_ok in the same cycle as req) → requester sees both oks in one cycle; the next request is granted the following cycle; no lost or duplicated data_ok.
- Stray mem_data_ok pulse while IDLE with no requests → no *_data_ok asserted, state stays IDLE.
- rst asserted while in DATA → next cycle state=IDLE, streak=0, all oks and mem_req=0; a new inst_req after rst deasserts is granted normally.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache memory-port arbiter.
// State, master id and access-size codes.
package cache_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10
  } state_e;

  typedef enum logic {
    M_INST = 1'b0,
    M_DATA = 1'b1
  } master_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_bus_arbiter_prio.sv
// Two-input priority picker: data first, inst
// wins once the data streak is saturated.
module bus_prio_pick
  import cache_bus_pkg::*;
(
  input  logic    inst_req_i,
  input  logic    data_req_i,
  input  logic    streak_full_i,
  output logic    grant_valid_o,
  output master_e grant_id_o
);

  always_comb begin
    grant_valid_o = inst_req_i | data_req_i;
    grant_id_o    = M_DATA;
    if (inst_req_i && (!data_req_i || streak_full_i))
      grant_id_o = M_INST;
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one SRAM-like memory port between the
// inst and data cache miss paths, one txn at a time.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int STREAK_MAX = 4,
  parameter int CNT_W      = $clog2(STREAK_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  state_e           state_q, state_d;
  master_e          owner_q, owner_d;
  logic [CNT_W-1:0] streak_q, streak_d;

  logic    grant_valid;
  master_e grant_id;
  logic    streak_full;
  logic    sel_req;
  master_e sel_id;
  logic    addr_hs;
  logic    data_hs;

  assign streak_full = (streak_q == CNT_W'(STREAK_MAX));

  bus_prio_pick u_pick (
    .inst_req_i    (inst_req),
    .data_req_i    (data_req),
    .streak_full_i (streak_full),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    sel_req = 1'b0;
    sel_id  = owner_q;
    unique case (state_q)
      S_IDLE: begin
        sel_req = grant_valid;
        sel_id  = grant_id;
      end
      S_ADDR:  sel_req = 1'b1;
      default: sel_req = 1'b0;
    endcase
  end

  always_comb begin
    mem_req = sel_req & ~rst;
    if (sel_id == M_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Stray data_ok in an idle cycle with no grant is dropped.
  assign addr_hs = mem_addr_ok & mem_req;
  assign data_hs = mem_data_ok & ~rst
                 & ((state_q != S_IDLE) | grant_valid);

  assign inst_addr_ok = addr_hs & (sel_id == M_INST);
  assign data_addr_ok = addr_hs & (sel_id == M_DATA);
  assign inst_data_ok = data_hs & (sel_id == M_INST);
  assign data_data_ok = data_hs & (sel_id == M_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_id;
          if (!addr_hs)        state_d = S_ADDR;
          else if (!data_hs)   state_d = S_DATA;
        end
      end
      S_ADDR: begin
        if (addr_hs)
          state_d = data_hs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mem_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (addr_hs) begin
      if (sel_id == M_DATA && inst_req)
        streak_d = streak_full ? streak_q : streak_q + 1'b1;
      else
        streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= M_DATA;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: vector table
// plus hand sequences for latency, streak and reset.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr),
    .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b1;
    data_req = 1'b1;
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_oks", {28'd0, inst_addr_ok, inst_data_ok,
                    data_addr_ok, data_data_ok}, 0);
    step();
    rst = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  typedef struct {
    logic        ir, dr, aok, dok;
    logic [31:0] rdata;
    logic        ereq, egnt;
    logic        eiaok, edaok, eidok, eddok;
    logic [2:0]  estreak;
  } vec_t;

  localparam int NV = 12;
  vec_t vt[NV];

  localparam logic [31:0] IA = 32'h0000_2000;
  localparam logic [31:0] DA = 32'h8000_0100;
  localparam logic [31:0] DW = 32'hCAFE_0001;

  logic [31:0] exp_addr;
  int ia_n, id_n, d_n;
  string order;
  logic [7:0] got_g;

  initial begin
    vt[0]  = '{0,0,1,1,32'h1111_1111,0,0,0,0,0,0,0};
    vt[1]  = '{1,0,1,1,32'hA000_0001,1,0,1,0,1,0,0};
    vt[2]  = '{0,1,1,1,32'hA000_0002,1,1,0,1,0,1,0};
    vt[3]  = '{1,1,1,1,32'hA000_0003,1,1,0,1,0,1,1};
    vt[4]  = '{1,1,1,1,32'hA000_0004,1,1,0,1,0,1,2};
    vt[5]  = '{1,1,1,1,32'hA000_0005,1,1,0,1,0,1,3};
    vt[6]  = '{1,1,1,1,32'hA000_0006,1,1,0,1,0,1,4};
    vt[7]  = '{1,1,1,1,32'hA000_0007,1,0,1,0,1,0,0};
    vt[8]  = '{1,1,1,1,32'hA000_0008,1,1,0,1,0,1,1};
    vt[9]  = '{0,1,1,1,32'hA000_0009,1,1,0,1,0,1,0};
    vt[10] = '{1,1,1,1,32'hA000_000A,1,1,0,1,0,1,1};
    vt[11] = '{1,1,1,1,32'hA000_000B,1,1,0,1,0,1,2};

    inst_wr = 1'b0; inst_size = SZ_WORD;
    inst_addr = IA; inst_wdata = 32'h0;
    data_wr = 1'b1; data_size = SZ_HALF;
    data_addr = DA; data_wdata = DW;
    mem_rdata = 32'h0;
    step();
    do_reset();
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rst_streak", 32'(dut.streak_q), 0);
    chk("rst_owner", 32'(dut.owner_q), 32'(M_DATA));

    // zero-latency memory: each vector completes in one cycle
    for (int i = 0; i < NV; i++) begin
      inst_req = vt[i].ir;
      data_req = vt[i].dr;
      mem_addr_ok = vt[i].aok;
      mem_data_ok = vt[i].dok;
      mem_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vt[i].ereq));
      chk($sformatf("v%0d_oks", i),
          {28'd0, inst_addr_ok, data_addr_ok,
           inst_data_ok, data_data_ok},
          {28'd0, vt[i].eiaok, vt[i].edaok,
           vt[i].eidok, vt[i].eddok});
      if (vt[i].ereq) begin
        exp_addr = vt[i].egnt ? DA : IA;
        chk($sformatf("v%0d_addr", i), mem_addr, exp_addr);
        chk($sformatf("v%0d_wr", i), 32'(mem_wr), 32'(vt[i].egnt));
      end
      if (vt[i].eidok)
        chk($sformatf("v%0d_irdata", i), inst_rdata, vt[i].rdata);
      if (vt[i].eddok)
        chk($sformatf("v%0d_drdata", i), data_rdata, vt[i].rdata);
      step();
      chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(S_IDLE));
      chk($sformatf("v%0d_streak", i), 32'(dut.streak_q),
          32'(vt[i].estreak));
    end

    // inst read, addr_ok after 2 cycles, data_ok 3 later
    do_reset();
    ia_n = 0; id_n = 0; d_n = 0;
    for (int c = 0; c < 10; c++) begin
      inst_req = (c <= 2);
      mem_addr_ok = (c == 2);
      mem_data_ok = (c == 5);
      mem_rdata = (c == 5) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      ia_n += int'(inst_addr_ok);
      id_n += int'(inst_data_ok);
      d_n += int'(data_addr_ok) + int'(data_data_ok);
      if (c <= 2) chk("a_hold_req", 32'(mem_req), 1);
      if (c == 3) chk("a_data_noreq", 32'(mem_req), 0);
      if (inst_data_ok) chk("a_rdata", inst_rdata, 32'hDEAD_BEEF);
      step();
    end
    chk("a_iaok_cnt", ia_n, 1);
    chk("a_idok_cnt", id_n, 1);
    chk("a_data_oks", d_n, 0);
    chk("a_state", 32'(dut.state_q), 32'(S_IDLE));

    // both held: data write first, inst right after its data_ok
    inst_req = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_size = SZ_WORD;
    data_addr = 32'h1000_0040; data_wdata = 32'h1234_5678;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    @(negedge clk);
    chk("b_addr", mem_addr, 32'h1000_0040);
    chk("b_wr", 32'(mem_wr), 1);
    chk("b_wdata", mem_wdata, 32'h1234_5678);
    chk("b_aoks", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    step();
    data_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    chk("b_wait_req", 32'(mem_req), 0);
    step();
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("b_dok", {30'd0, data_data_ok, inst_data_ok}, 32'd2);
    step();
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    chk("b_inst_aok", 32'(inst_addr_ok), 1);
    chk("b_inst_addr", mem_addr, IA);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("b_inst_dok", 32'(inst_data_ok), 1);
    step();
    mem_data_ok = 1'b0;

    // streak fairness with both masters always requesting
    do_reset();
    order = "DDDDIDDDDI";
    inst_req = 1'b1; data_req = 1'b1;
    for (int t = 0; t < 10; t++) begin
      mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
      @(negedge clk);
      got_g = data_addr_ok ? "D" : (inst_addr_ok ? "I" : "?");
      chk($sformatf("c_grant%0d", t), 32'(got_g), 32'(order[t]));
      step();
      if (order[t] == "I")
        chk($sformatf("c_streak%0d", t), 32'(dut.streak_q), 0);
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      step();
    end
    mem_data_ok = 1'b0;

    // reset while a transaction is in DATA
    mem_addr_ok = 1'b1;
    step();
    chk("f_pre_state", 32'(dut.state_q), 32'(S_DATA));
    chk("f_pre_streak", 32'(dut.streak_q), 1);
    data_req = 1'b0; rst = 1'b1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("f_rst_req", 32'(mem_req), 0);
    chk("f_rst_oks", {28'd0, inst_addr_ok, inst_data_ok,
                      data_addr_ok, data_data_ok}, 0);
    step();
    rst = 1'b0; mem_data_ok = 1'b0;
    chk("f_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("f_streak", 32'(dut.streak_q), 0);
    @(negedge clk);
    chk("f_new_aok", 32'(inst_addr_ok), 1);
    chk("f_new_addr", mem_addr, IA);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    chk("f_new_dok", 32'(inst_data_ok), 1);
    step();
    mem_data_ok = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
